// File: rtl/led_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_decoder
// Brief  : Glitch-filters an 8-LED bus and tracks the 13-step walking/flash
//          sequence; reports lock, step strobes, cycle count and errors.
//          Option macro LED_PATTERN_DECODER_DWELL_CAPTURE_EN adds Last_Dwell.
// Rev    : 1.0
// ============================================================================
module led_pattern_decoder #(
    parameter int FILTER_CYC  = 4,
    parameter int TIMEOUT_CYC = 16_000_000
) (
    input  logic        Clk_50MHz,
    input  logic        Reset_Onboard,
    input  logic [7:0]  LED_In,
    output logic [3:0]  Step_Index,
    output logic        Step_Strobe,
    output logic        Locked,
    output logic        Cycle_Done,
    output logic [15:0] Cycle_Count,
    output logic        Seq_Error,
    output logic [7:0]  Error_Count,
    output logic [27:0] Last_Dwell
);

    localparam logic [7:0]  C_FILTER_LAST  = 8'(FILTER_CYC - 1);
    localparam logic [27:0] C_TIMEOUT_LAST = 28'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  C_CLS_ZERO     = 4'd8;
    localparam logic [3:0]  C_CLS_ONES     = 4'd9;
    localparam logic [3:0]  C_CLS_INVALID  = 4'd15;
    localparam logic [3:0]  C_LAST_STEP    = 4'd12;

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t      state_q;
    logic [7:0]  sync1_q, sync2_q, prev_q, accepted_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic        accept_q, accept_d;
    logic        event_q;
    logic [3:0]  class_q, class_d;
    logic [3:0]  step_next_d, expect_d;
    logic [27:0] dwell_q;
    logic        timeout_d;

    always_comb begin
        stab_cnt_d  = 8'd0;
        accept_d    = 1'b0;
        class_d     = C_CLS_INVALID;
        step_next_d = 4'd0;
        expect_d    = 4'd0;
        timeout_d   = 1'b0;

        // Count uses the next value so a change is accepted FILTER_CYC+2 cycles later.
        if (sync2_q == prev_q) begin
            stab_cnt_d = (stab_cnt_q == 8'hFF) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
        accept_d = (stab_cnt_d == C_FILTER_LAST) && (sync2_q != accepted_q);

        case (accepted_q)
            8'h80:   class_d = 4'd0;
            8'h40:   class_d = 4'd1;
            8'h20:   class_d = 4'd2;
            8'h10:   class_d = 4'd3;
            8'h08:   class_d = 4'd4;
            8'h04:   class_d = 4'd5;
            8'h02:   class_d = 4'd6;
            8'h01:   class_d = 4'd7;
            8'h00:   class_d = C_CLS_ZERO;
            8'hFF:   class_d = C_CLS_ONES;
            default: class_d = C_CLS_INVALID;
        endcase

        step_next_d = (Step_Index == C_LAST_STEP) ? 4'd0 : Step_Index + 4'd1;
        // Steps 8,10,12 show all-off and 9,11 all-on.
        if (step_next_d <= 4'd7) begin
            expect_d = step_next_d;
        end else if (!step_next_d[0]) begin
            expect_d = C_CLS_ZERO;
        end else begin
            expect_d = C_CLS_ONES;
        end

        timeout_d = (dwell_q == C_TIMEOUT_LAST);
    end

    always_ff @(posedge Clk_50MHz) begin
        if (Reset_Onboard) begin
            state_q     <= ST_HUNT;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            accepted_q  <= '0;
            stab_cnt_q  <= '0;
            accept_q    <= 1'b0;
            event_q     <= 1'b0;
            class_q     <= '0;
            dwell_q     <= '0;
            Step_Index  <= '0;
            Step_Strobe <= 1'b0;
            Locked      <= 1'b0;
            Cycle_Done  <= 1'b0;
            Cycle_Count <= '0;
            Seq_Error   <= 1'b0;
            Error_Count <= '0;
        end else begin
            sync1_q    <= LED_In;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stab_cnt_q <= stab_cnt_d;
            accept_q   <= accept_d;
            if (accept_d) begin
                accepted_q <= sync2_q;
            end
            event_q <= accept_q;
            class_q <= class_d;

            Step_Strobe <= 1'b0;
            Cycle_Done  <= 1'b0;
            Seq_Error   <= 1'b0;

            case (state_q)
                ST_HUNT: begin
                    Locked     <= 1'b0;
                    Step_Index <= 4'd0;
                    dwell_q    <= '0;
                    if (event_q && class_q == 4'd0) begin
                        state_q <= ST_TRACK;
                        Locked  <= 1'b1;
                    end
                end
                default: begin
                    if (event_q) begin
                        dwell_q <= '0;
                        if (class_q == expect_d) begin
                            Step_Index  <= step_next_d;
                            Step_Strobe <= 1'b1;
                            if (Step_Index == C_LAST_STEP) begin
                                Cycle_Done <= 1'b1;
                                if (Cycle_Count != 16'hFFFF) begin
                                    Cycle_Count <= Cycle_Count + 16'd1;
                                end
                            end
                        end else begin
                            Seq_Error  <= 1'b1;
                            Step_Index <= 4'd0;
                            if (Error_Count != 8'hFF) begin
                                Error_Count <= Error_Count + 8'd1;
                            end
                            if (class_q != 4'd0) begin
                                state_q <= ST_HUNT;
                                Locked  <= 1'b0;
                            end
                        end
                    end else if (timeout_d) begin
                        Seq_Error  <= 1'b1;
                        Step_Index <= 4'd0;
                        dwell_q    <= '0;
                        state_q    <= ST_HUNT;
                        Locked     <= 1'b0;
                        if (Error_Count != 8'hFF) begin
                            Error_Count <= Error_Count + 8'd1;
                        end
                    end else if (dwell_q != 28'hFFF_FFFF) begin
                        dwell_q <= dwell_q + 28'd1;
                    end
                end
            endcase
        end
    end

`ifdef LED_PATTERN_DECODER_DWELL_CAPTURE_EN
    logic [27:0] last_dwell_q;

    always_ff @(posedge Clk_50MHz) begin
        if (Reset_Onboard) begin
            last_dwell_q <= '0;
        end else if (state_q == ST_TRACK && event_q) begin
            last_dwell_q <= dwell_q + 28'd1;
        end
    end

    assign Last_Dwell = last_dwell_q;
`else
    assign Last_Dwell = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_led_pattern_decoder
// Brief  : Directed self-checking bench for led_pattern_decoder
//          (FILTER_CYC=2, TIMEOUT_CYC=40).
// Rev    : 1.0
// ============================================================================
module tb_led_pattern_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  led;
    logic [3:0]  step_index;
    logic        step_strobe;
    logic        locked;
    logic        cycle_done;
    logic [15:0] cycle_count;
    logic        seq_error;
    logic [7:0]  error_count;
    logic [27:0] last_dwell;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_done = 0;
    int n_seqerr = 0;
    int last_err_cyc = 0;
    int t0;
    int strobes_before;
    logic [3:0] strobe_hist [0:31];

`ifdef LED_PATTERN_DECODER_DWELL_CAPTURE_EN
    localparam logic [27:0] C_EXP_DWELL30 = 28'd30;
    localparam logic [27:0] C_EXP_DWELL10 = 28'd10;
`else
    localparam logic [27:0] C_EXP_DWELL30 = 28'd0;
    localparam logic [27:0] C_EXP_DWELL10 = 28'd0;
`endif

    led_pattern_decoder #(
        .FILTER_CYC  (2),
        .TIMEOUT_CYC (40)
    ) u_dut (
        .Clk_50MHz     (clk),
        .Reset_Onboard (rst),
        .LED_In        (led),
        .Step_Index    (step_index),
        .Step_Strobe   (step_strobe),
        .Locked        (locked),
        .Cycle_Done    (cycle_done),
        .Cycle_Count   (cycle_count),
        .Seq_Error     (seq_error),
        .Error_Count   (error_count),
        .Last_Dwell    (last_dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pulses are tallied on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (step_strobe) begin
            if (n_strobe < 32) strobe_hist[n_strobe] = step_index;
            n_strobe = n_strobe + 1;
        end
        if (cycle_done) n_done = n_done + 1;
        if (seq_error) begin
            n_seqerr     = n_seqerr + 1;
            last_err_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        led = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq_a [12];
        logic [7:0] seq_b [9];
        seq_a = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                  8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        seq_b = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'hFF};

        rst = 1'b1;
        led = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_locked",  32'(locked),      32'd0);
        check_val("rst_index",   32'(step_index),  32'd0);
        check_val("rst_strobe",  32'(step_strobe), 32'd0);
        check_val("rst_done",    32'(cycle_done),  32'd0);
        check_val("rst_ccount",  32'(cycle_count), 32'd0);
        check_val("rst_seqerr",  32'(seq_error),   32'd0);
        check_val("rst_ecount",  32'(error_count), 32'd0);
        check_val("rst_dwell",   32'(last_dwell),  32'd0);
        rst = 1'b0;

        // Full cycle, step 12 held 30 cycles in total
        hold(8'h80, 10);
        check_val("lock_locked", 32'(locked),     32'd1);
        check_val("lock_index",  32'(step_index), 32'd0);
        check_val("lock_nostrb", 32'(n_strobe),   32'd0);
        for (int i = 0; i < 12; i++) hold(seq_a[i], 10);
        hold(8'h00, 20);
        check_val("cyc_strobes", 32'(n_strobe),   32'd12);
        check_val("cyc_index12", 32'(step_index), 32'd12);
        check_val("cyc_nodone",  32'(n_done),     32'd0);
        for (int i = 0; i < 12; i++) check_val($sformatf("hist%0d", i), 32'(strobe_hist[i]), 32'(i + 1));
        hold(8'h80, 10);
        check_val("wrap_strobes", 32'(n_strobe),       32'd13);
        check_val("wrap_hist",    32'(strobe_hist[12]), 32'd0);
        check_val("wrap_done",    32'(n_done),         32'd1);
        check_val("wrap_ccount",  32'(cycle_count),    32'd1);
        check_val("wrap_index",   32'(step_index),     32'd0);
        check_val("wrap_noerr",   32'(n_seqerr),       32'd0);
        check_val("wrap_dwell",   32'(last_dwell),     32'(C_EXP_DWELL30));

        // Glitch on step 3
        hold(8'h40, 10);
        hold(8'h20, 10);
        hold(8'h10, 10);
        hold(8'h55, 1);
        hold(8'h10, 10);
        check_val("glitch_index",  32'(step_index),  32'd3);
        check_val("glitch_ecount", 32'(error_count), 32'd0);
        check_val("glitch_noerr",  32'(n_seqerr),    32'd0);
        check_val("glitch_strb",   32'(n_strobe),    32'd16);

        // Out-of-order 80 resyncs to step 0 without losing lock
        hold(8'h80, 10);
        check_val("resync_err",    32'(n_seqerr),    32'd1);
        check_val("resync_ecount", 32'(error_count), 32'd1);
        check_val("resync_locked", 32'(locked),      32'd1);
        check_val("resync_index",  32'(step_index),  32'd0);

        // Skipped step from step 2
        hold(8'h40, 10);
        hold(8'h20, 10);
        hold(8'h08, 10);
        check_val("skip_err",    32'(n_seqerr),    32'd2);
        check_val("skip_ecount", 32'(error_count), 32'd2);
        check_val("skip_locked", 32'(locked),      32'd0);
        check_val("skip_index",  32'(step_index),  32'd0);

        // Relock latency: accept after 4 edges, Locked two edges later
        led = 8'h80;
        repeat (5) @(posedge clk);
        #1;
        check_val("relock_early", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        check_val("relock_on",    32'(locked), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_val("relock_index", 32'(step_index), 32'd0);
        check_val("relock_strb",  32'(n_strobe),   32'd18);

        // Timeout on step 5
        hold(8'h40, 10);
        hold(8'h20, 10);
        hold(8'h10, 10);
        hold(8'h08, 10);
        t0 = cyc;
        hold(8'h04, 50);
        check_val("to_err",     32'(n_seqerr),          32'd3);
        check_val("to_when",    32'(last_err_cyc - t0), 32'd46);
        check_val("to_ecount",  32'(error_count),       32'd3);
        check_val("to_locked",  32'(locked),            32'd0);
        check_val("to_dwell",   32'(last_dwell),        32'(C_EXP_DWELL10));
        hold(8'h04, 50);
        check_val("to_once",    32'(n_seqerr),          32'd3);

        // Reset during step 9
        hold(8'h80, 10);
        for (int i = 0; i < 9; i++) hold(seq_b[i], 10);
        check_val("pre_rst_index",  32'(step_index),  32'd9);
        check_val("pre_rst_ccount", 32'(cycle_count), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_locked", 32'(locked),      32'd0);
        check_val("mid_rst_index",  32'(step_index),  32'd0);
        check_val("mid_rst_ccount", 32'(cycle_count), 32'd0);
        check_val("mid_rst_ecount", 32'(error_count), 32'd0);
        check_val("mid_rst_pulses", 32'({step_strobe, cycle_done, seq_error}), 32'd0);
        check_val("mid_rst_dwell",  32'(last_dwell),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        strobes_before = n_strobe;
        hold(8'h80, 10);
        check_val("post_rst_locked", 32'(locked),     32'd1);
        check_val("post_rst_index",  32'(step_index), 32'd0);
        check_val("post_rst_nostrb", 32'(n_strobe),   32'(strobes_before));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
